// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and sizing constants for the program loader
package program_loader_pkg;
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE} state_t;
   localparam int MEM_WORDS_DEFAULT = 256;
   localparam int HDR_BYTES = 2;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts bytes in little-endian into a 32-bit word.
// Ports: clk, reset (async, active high), clear (restart at byte 0),
// byte_in/strobe (accept one byte), word (assembled bytes), word_full (next strobe completes the word).
module word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        strobe,
   output logic [31:0] word,
   output logic        word_full
);
   logic [1:0] idx;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         idx  <= '0;
         word <= '0;
      end else if (clear) begin
         idx  <= '0;
         word <= '0;
      end else if (strobe) begin
         idx  <= idx + 2'd1;
         word <= {byte_in, word[31:8]};
      end
   // High while three bytes are held, so the FSM can leave DATA on the edge that takes the fourth
   assign word_full = idx == 2'd3;
endmodule

// File: rtl/program_loader.sv
// program_loader: loads a length-prefixed byte stream into program memory while holding the core.
// Ports: clk, reset (async, active high), start, rx_data/rx_valid/rx_ready (byte stream),
// mem_byte_address/mem_write_enable/mem_write_data (memory write port),
// cpu_hold, load_done, load_error (status), words_written (words committed this load).
module program_loader
   import program_loader_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [31:0]      mem_byte_address,
   output logic             mem_write_enable,
   output logic [31:0]      mem_write_data,
   output logic             cpu_hold,
   output logic             load_done,
   output logic             load_error,
   output logic [CNT_W-1:0] words_written
);
   state_t           state;
   logic [CNT_W-1:0] len;
   logic [CNT_W-1:0] hdr;
   logic             word_full;
   assign rx_ready = state inside {LEN_LO, LEN_HI, DATA};
   // Full header: the byte arriving in LEN_HI over the low byte captured in LEN_LO
   assign hdr = CNT_W'({rx_data, len[7:0]});
   word_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (state == IDLE && start),
      .byte_in   (rx_data),
      .strobe    (state == DATA && rx_valid),
      .word      (mem_write_data),
      .word_full (word_full)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state            <= IDLE;
         len              <= '0;
         mem_byte_address <= '0;
         mem_write_enable <= 1'b0;
         cpu_hold         <= 1'b0;
         load_done        <= 1'b0;
         load_error       <= 1'b0;
         words_written    <= '0;
      end else begin
         mem_write_enable <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  state         <= LEN_LO;
                  load_done     <= 1'b0;
                  load_error    <= 1'b0;
                  words_written <= '0;
                  cpu_hold      <= 1'b1;
               end
            LEN_LO:
               if (rx_valid) begin
                  len   <= CNT_W'(rx_data);
                  state <= LEN_HI;
               end
            LEN_HI:
               if (rx_valid) begin
                  if (hdr == '0)
                     state <= DONE;
                  else if (32'(hdr) > 32'(MEM_WORDS)) begin
                     load_error <= 1'b1;
                     cpu_hold   <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     len   <= hdr;
                     state <= DATA;
                  end
               end
            DATA:
               if (rx_valid && word_full) begin
                  state            <= WRITE;
                  mem_write_enable <= 1'b1;
                  mem_byte_address <= 32'({words_written, 2'b00});
               end
            WRITE: begin
               words_written <= words_written + CNT_W'(1);
               state         <= (words_written + CNT_W'(1) == len) ? DONE : DATA;
            end
            DONE: begin
               load_done <= 1'b1;
               cpu_hold  <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed loads checked against a byte-stream reference model
module tb_program_loader;
   localparam int MEM = 256;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [31:0] mem_byte_address;
   logic        mem_write_enable;
   logic [31:0] mem_write_data;
   logic        cpu_hold;
   logic        load_done;
   logic        load_error;
   logic [15:0] words_written;
   int          checks = 0;
   int          fails = 0;
   logic [31:0] obs_a[$];
   logic [31:0] obs_d[$];
   logic [7:0]  payload[$];

   program_loader #(.MEM_WORDS(MEM), .CNT_W(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready),
      .mem_byte_address (mem_byte_address),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .cpu_hold         (cpu_hold),
      .load_done        (load_done),
      .load_error       (load_error),
      .words_written    (words_written)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (mem_write_enable) begin
         obs_a.push_back(mem_byte_address);
         obs_d.push_back(mem_write_data);
         chk("ready_in_write", 32'(rx_ready), 0);
      end

   task automatic send(input logic [7:0] b, input bit gaps);
      bit took = 1'b0;
      for (int i = 0; i < 200 && !took; i++) begin
         @(negedge clk);
         start    = 1'b0;
         rx_data  = b;
         rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         took     = rx_valid && rx_ready;
      end
      if (!took) chk("send_timeout", 0, 1);
   endtask

   task automatic run(input int n, input bit gaps, input bit poke);
      bit err = n > MEM;
      int nexp = err ? 0 : n;
      obs_a.delete();
      obs_d.delete();
      @(negedge clk);
      start    = 1'b1;
      rx_valid = 1'b0;
      send(n[7:0], gaps);
      send(n[15:8], gaps);
      if (!err && n > 0) begin
         chk("hold_busy", 32'(cpu_hold), 1);
         for (int k = 0; k < payload.size(); k++) begin
            if (poke && k == 2) begin
               @(negedge clk);
               rx_valid = 1'b0;
               start    = 1'b1;
            end
            send(payload[k], gaps);
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b0;
      if (n == 0) begin
         @(negedge clk);
         chk("zero_done_latency", 32'(load_done), 1);
      end
      for (int t = 0; t < 20 && cpu_hold; t++) @(negedge clk);
      chk("hold_release", 32'(cpu_hold), 0);
      chk("load_done", 32'(load_done), 32'(!err));
      chk("load_error", 32'(load_error), 32'(err));
      chk("words_written", 32'(words_written), nexp);
      chk("num_writes", obs_a.size(), nexp);
      for (int k = 0; k < nexp && k < obs_a.size(); k++) begin
         chk("wr_addr", obs_a[k], 4 * k);
         chk("wr_data", obs_d[k], {payload[4*k+3], payload[4*k+2], payload[4*k+1], payload[4*k]});
      end
      if (nexp > 0) chk("addr_hold", mem_byte_address, 4 * (nexp - 1));
   endtask

   task automatic rand_payload(input int n);
      payload.delete();
      for (int k = 0; k < 4 * n; k++) payload.push_back(8'($urandom));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(rx_ready), 0);
      chk("rst_we", 32'(mem_write_enable), 0);
      chk("rst_addr", mem_byte_address, 0);
      chk("rst_wdata", mem_write_data, 0);
      chk("rst_hold", 32'(cpu_hold), 0);
      chk("rst_flags", {30'd0, load_done, load_error}, 0);
      chk("rst_ww", 32'(words_written), 0);
      reset = 1'b0;
      payload = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
      run(2, 1'b0, 1'b0);
      payload.delete();
      run(0, 1'b0, 1'b0);
      run(257, 1'b0, 1'b0);
      payload = '{8'h11, 8'h22, 8'h33, 8'h44};
      run(1, 1'b1, 1'b0);
      obs_a.delete();
      @(negedge clk);
      start = 1'b1;
      send(8'h01, 1'b0);
      send(8'h00, 1'b0);
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      @(negedge clk);
      rx_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(rx_ready), 0);
      chk("mid_rst_hold", 32'(cpu_hold), 0);
      chk("mid_rst_wdata", mem_write_data, 0);
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_nowrite", obs_a.size(), 0);
      payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run(1, 1'b0, 1'b0);
      rand_payload(3);
      run(3, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         int n = $urandom_range(1, 6);
         rand_payload(n);
         run(n, 1'b1, 1'b0);
      end
      rand_payload(MEM);
      run(MEM, 1'b1, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
